// File: rtl/fp16_approx_mac_unit.sv
// Approximate binary16 multiply-accumulate: truncating multiply and add with
// flush-to-zero inputs, saturating overflow, and a single 16-bit accumulator.
module fp16_approx_mac_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] acc_out
);

    logic [15:0]       acc_q, acc_d;

    logic              p_zero, p_sat, p_sign;
    logic signed [7:0] p_exp;
    logic [10:0]       p_sig;
    logic [21:0]       prod;

    logic              x_big, s_big, s_small;
    logic [4:0]        e_big, e_small, dexp;
    logic [10:0]       sig_big, sig_small, sig_sh, diff, res_sig;
    logic [11:0]       sum;
    logic [3:0]        msb, lz;
    logic signed [7:0] res_exp;
    logic              res_sign, res_zero;

    always_comb begin
        p_sign = a[15] ^ b[15];
        prod   = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
        p_exp  = $signed({3'b0, a[14:10]}) + $signed({3'b0, b[14:10]}) - 8'sd15;
        p_sig  = prod[20:10];
        if (prod[21]) begin
            p_sig = prod[21:11];
            p_exp = p_exp + 8'sd1;
        end
        p_zero = (a[14:10] == 5'd0) || (b[14:10] == 5'd0);
        p_sat  = !p_zero && ((a[14:10] == 5'd31) || (b[14:10] == 5'd31));
        // Product range faults fold into the zero/saturate paths so the adder only sees normals.
        if (!p_zero && !p_sat) begin
            if (p_exp <= 8'sd0)
                p_zero = 1'b1;
            else if (p_exp >= 8'sd31)
                p_sat = 1'b1;
        end
    end

    always_comb begin
        x_big     = (acc_q[14:10] > p_exp[4:0]) ||
                    ((acc_q[14:10] == p_exp[4:0]) && ({1'b1, acc_q[9:0]} >= p_sig));
        s_big     = x_big ? acc_q[15]          : p_sign;
        s_small   = x_big ? p_sign             : acc_q[15];
        e_big     = x_big ? acc_q[14:10]       : p_exp[4:0];
        e_small   = x_big ? p_exp[4:0]         : acc_q[14:10];
        sig_big   = x_big ? {1'b1, acc_q[9:0]} : p_sig;
        sig_small = x_big ? p_sig              : {1'b1, acc_q[9:0]};
        dexp      = e_big - e_small;
        sig_sh    = sig_small >> dexp;

        res_exp  = $signed({3'b0, e_big});
        res_sign = s_big;
        res_zero = 1'b0;
        res_sig  = '0;
        sum      = '0;
        diff     = '0;
        msb      = '0;
        lz       = '0;

        if (s_big == s_small) begin
            sum = {1'b0, sig_big} + {1'b0, sig_sh};
            if (sum[11]) begin
                res_sig = sum[11:1];
                res_exp = res_exp + 8'sd1;
            end else begin
                res_sig = sum[10:0];
            end
        end else begin
            diff = sig_big - sig_sh;
            for (int unsigned i = 0; i < 11; i++)
                if (diff[i]) msb = i[3:0];
            lz       = 4'd10 - msb;
            res_sig  = diff << lz;
            res_exp  = res_exp - $signed({4'b0, lz});
            res_zero = (diff == 11'd0);
        end

        acc_d = acc_q;
        if (enable && !p_zero) begin
            if (p_sat)
                acc_d = {p_sign, 15'h7BFF};
            else if (acc_q[14:10] == 5'd0)
                acc_d = {p_sign, p_exp[4:0], p_sig[9:0]};
            else if (res_zero || res_exp <= 8'sd0)
                acc_d = '0;
            else if (res_exp >= 8'sd31)
                acc_d = {res_sign, 15'h7BFF};
            else
                acc_d = {res_sign, res_exp[4:0], res_sig[9:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            acc_q <= '0;
        else
            acc_q <= acc_d;
    end

    assign acc_out = acc_q;

endmodule

// File: tb/tb_fp16_approx_mac_unit.sv
// Scoreboarded directed-vector bench for fp16_approx_mac_unit.
module tb_fp16_approx_mac_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic [15:0] acc_out;

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    fp16_approx_mac_unit dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .a       (a),
        .b       (b),
        .acc_out (acc_out)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [15:0] act, logic [15:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Monitor: the accumulator is a fresh result after every edge, checked at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk(e.name, acc_out, e.val);
            end
        end
    end

    task automatic step(string name, logic en, logic [15:0] av, logic [15:0] bv, logic [15:0] ev);
        enable = en;
        a      = av;
        b      = bv;
        @(posedge clk);
        #1;
        exp_q.push_back('{name, ev});
    endtask

    task automatic do_reset(string name);
        @(negedge clk);
        #1;
        enable = 1'b1;
        a      = 16'h4000;
        b      = 16'h4000;
        rst    = 1'b0;
        #1;
        chk({name, "_async"}, acc_out, 16'h0000);
        @(posedge clk);
        #1;
        chk({name, "_held"}, acc_out, 16'h0000);
        rst    = 1'b1;
        enable = 1'b0;
    endtask

    initial begin
        #2;
        chk("por", acc_out, 16'h0000);
        rst = 1'b1;

        do_reset("r1");
        step("one_1", 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
        step("one_2", 1'b1, 16'h3C00, 16'h3C00, 16'h4000);
        step("one_3", 1'b1, 16'h3C00, 16'h3C00, 16'h4200);

        do_reset("r2");
        step("zero_a1", 1'b1, 16'h0000, 16'h3C00, 16'h0000);
        step("zero_a2", 1'b1, 16'h0000, 16'h4000, 16'h0000);

        do_reset("r3");
        step("two_sq", 1'b1, 16'h4000, 16'h4000, 16'h4400);
        do_reset("mid_rst");
        step("post_rst", 1'b0, 16'h4000, 16'h4000, 16'h0000);

        for (int i = 0; i < 4; i++)
            step("hold_en0", 1'b0, 16'h4000, 16'h4000, 16'h0000);

        do_reset("r4");
        begin
            logic [15:0] q_exp [10] = '{16'h3400, 16'h3800, 16'h3A00, 16'h3C00, 16'h3D00,
                                        16'h3E00, 16'h3F00, 16'h4000, 16'h4080, 16'h4100};
            for (int i = 0; i < 10; i++)
                step("quarter", 1'b1, 16'h3800, 16'h3800, q_exp[i]);
        end

        do_reset("r5");
        step("sgn_one", 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
        step("cancel", 1'b1, 16'hBC00, 16'h3C00, 16'h0000);
        step("sat_1", 1'b1, 16'h7BFF, 16'h7BFF, 16'h7BFF);
        step("sat_2", 1'b1, 16'h7BFF, 16'h7BFF, 16'h7BFF);
        step("sat_hold", 1'b0, 16'h1234, 16'h5678, 16'h7BFF);

        do_reset("r6");
        step("neg_sat", 1'b1, 16'hFBFF, 16'h7BFF, 16'hFBFF);
        do_reset("r7");
        step("inf_in", 1'b1, 16'h7C00, 16'h3C00, 16'h7BFF);

        do_reset("r8");
        step("ftz_base", 1'b1, 16'h3C00, 16'h3C00, 16'h3C00);
        step("subnorm", 1'b1, 16'h0001, 16'h3C00, 16'h3C00);
        step("align_out", 1'b1, 16'h1000, 16'h3C00, 16'h3C00);

        do_reset("r9");
        step("trunc_mul", 1'b1, 16'h3C01, 16'h3C01, 16'h3C02);
        do_reset("r10");
        step("norm_mul", 1'b1, 16'h3E00, 16'h3E00, 16'h4080);

        do_reset("r11");
        step("sub_base", 1'b1, 16'h3E00, 16'h3C00, 16'h3E00);
        step("sub_lz", 1'b1, 16'hBC00, 16'h3C00, 16'h3800);
        step("sub_neg", 1'b1, 16'hBC00, 16'h3C00, 16'hB800);

        enable = 1'b0;
        begin
            int budget = 10;
            while (exp_q.size() > 0 && budget > 0) begin
                @(posedge clk);
                budget--;
            end
            if (exp_q.size() > 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain: got %0d pending expected 0", exp_q.size());
            end
        end
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
